// File: rtl/hs_gl.sv
// hs_gl: WIDTH-lane gate-level half subtractor with registered, valid-qualified copy and saturating borrow counter
module hs_gl #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output wire  [WIDTH-1:0] borrow,
  output wire  [WIDTH-1:0] difference,
  input  logic             in_valid,
  output logic [WIDTH-1:0] borrow_q,
  output logic [WIDTH-1:0] difference_q,
  output logic             out_valid,
  output logic             borrow_any,
  output logic [CNT_W-1:0] borrow_cnt,
  input  logic             cnt_clr
);
  logic [WIDTH-1:0] r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    wire w_n;
    not u_not (w_n, ip1[i]);
    and u_and (borrow[i], w_n, ip2[i]);
    xor u_xor (difference[i], ip1[i], ip2[i]);
  end
  assign borrow_any = |borrow;
  assign w_sat      = &r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrow <= '0;
      r_diff   <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_borrow <= borrow;
        r_diff   <= difference;
      end
      // clear wins over a same-cycle increment; saturate instead of wrapping
      if (cnt_clr) r_cnt <= '0;
      else if (in_valid && borrow_any && !w_sat) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign borrow_q     = r_borrow;
  assign difference_q = r_diff;
  assign out_valid    = r_valid;
  assign borrow_cnt   = r_cnt;
endmodule

// File: tb/tb_hs_gl.sv
// tb_hs_gl: random and directed checks of hs_gl against a lane-arithmetic reference model
module tb_hs_gl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ip1, ip2;
  logic       in_valid, cnt_clr;
  wire        b_a, d_a, bq_a, dq_a, ov_a, any_a;
  wire  [7:0] cnt_a;
  wire  [3:0] b_b, d_b, bq_b, dq_b;
  wire        ov_b, any_b;
  wire  [1:0] cnt_b;
  int total = 0, bad = 0;
  logic [3:0] m_bq_b, m_dq_b;
  logic       m_bq_a, m_dq_a, m_ov;
  int         m_cnt_a, m_cnt_b;
  always #5 clk = ~clk;
  hs_gl #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .ip1(ip1[0]), .ip2(ip2[0]), .borrow(b_a), .difference(d_a),
    .in_valid(in_valid), .borrow_q(bq_a), .difference_q(dq_a), .out_valid(ov_a),
    .borrow_any(any_a), .borrow_cnt(cnt_a), .cnt_clr(cnt_clr));
  hs_gl #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ip1(ip1), .ip2(ip2), .borrow(b_b), .difference(d_b),
    .in_valid(in_valid), .borrow_q(bq_b), .difference_q(dq_b), .out_valid(ov_b),
    .borrow_any(any_b), .borrow_cnt(cnt_b), .cnt_clr(cnt_clr));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // per-lane minuend minus subtrahend: borrow when negative, difference is the parity
  function automatic logic [3:0] ref_b(input logic [3:0] a, input logic [3:0] b);
    for (int l = 0; l < 4; l++) ref_b[l] = (int'(a[l]) - int'(b[l])) < 0;
  endfunction
  function automatic logic [3:0] ref_d(input logic [3:0] a, input logic [3:0] b);
    for (int l = 0; l < 4; l++) ref_d[l] = ((int'(a[l]) - int'(b[l])) & 1) != 0;
  endfunction
  task automatic chk_comb();
    chk("b_a", b_a, ref_b(ip1, ip2) & 4'h1);
    chk("d_a", d_a, ref_d(ip1, ip2) & 4'h1);
    chk("b_b", b_b, ref_b(ip1, ip2));
    chk("d_b", d_b, ref_d(ip1, ip2));
    chk("any_b", any_b, ref_b(ip1, ip2) != 0);
  endtask
  task automatic chk_regs();
    chk("ov_a", ov_a, m_ov);
    chk("ov_b", ov_b, m_ov);
    chk("bq_a", bq_a, m_bq_a);
    chk("dq_a", dq_a, m_dq_a);
    chk("bq_b", bq_b, m_bq_b);
    chk("dq_b", dq_b, m_dq_b);
    chk("cnt_a", cnt_a, m_cnt_a);
    chk("cnt_b", cnt_b, m_cnt_b);
  endtask
  task automatic model_reset();
    m_bq_a = 0; m_dq_a = 0; m_bq_b = 0; m_dq_b = 0; m_ov = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask
  task automatic cyc(input logic v, input logic [3:0] a, input logic [3:0] b, input logic clr);
    in_valid = v; ip1 = a; ip2 = b; cnt_clr = clr;
    #1 chk_comb();
    @(posedge clk);
    m_ov = v;
    if (v) begin
      m_bq_b = ref_b(a, b); m_dq_b = ref_d(a, b);
      m_bq_a = m_bq_b[0];   m_dq_a = m_dq_b[0];
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (v && m_bq_a && m_cnt_a < 255) m_cnt_a++;
      if (v && ref_b(a, b) != 0 && m_cnt_b < 3) m_cnt_b++;
    end
    @(negedge clk);
    chk_regs();
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; ip1 = '0; ip2 = '0;
    model_reset();
    #1 chk_regs();
    for (int k = 0; k < 4; k++) begin
      ip1 = 4'(k >> 1); ip2 = 4'(k & 1);
      #2 chk_comb();
    end
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b1, 4'b0000, 4'b0001, 1'b0);
    chk("first_bq", bq_a, 1); chk("first_dq", dq_a, 1); chk("first_cnt", cnt_a, 1);
    cyc(1'b1, 4'b0000, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0000, 4'b0001, 1'b0);
    cyc(1'b0, 4'b0001, 4'b0001, 1'b0);
    chk("hold_bq", bq_a, 1); chk("hold_dq", dq_a, 1); chk("hold_ov", ov_a, 0);
    chk("hold_cnt", cnt_a, 3);
    cyc(1'b1, 4'b0000, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0000, 4'b0001, 1'b0);
    chk("sat_cnt", cnt_b, 3); chk("cnt5", cnt_a, 5);
    cyc(1'b1, 4'b0000, 4'b0001, 1'b1);
    chk("clr_prio", cnt_b, 0); chk("clr_prio_a", cnt_a, 0);
    in_valid = 1'b1; ip1 = 4'b1010; ip2 = 4'b0110;
    #1 chk("w4_b", b_b, 4'b0100); chk("w4_d", d_b, 4'b1100); chk("w4_any", any_b, 1);
    cyc(1'b1, 4'b1010, 4'b0110, 1'b0);
    for (int n = 0; n < 300; n++) begin
      if (n % 53 == 17) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_regs(); chk_comb();
        ip1 = 4'($urandom); ip2 = 4'($urandom);
        #1 chk_comb();
        @(negedge clk) rst_n = 1'b1;
      end
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 9) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
